// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds and
// sticky overflow/underflow flags. All 2**ABITS entries are usable; read latency is 1 cycle.
// Optional build macro FIFO_STROBE_EDGE_EN: wr/rd become slow strobes, synchronised through
// two flops, and each falling edge produces exactly one request.
module fifo_sync_param #(
    parameter int unsigned DBITS    = 8,
    parameter int unsigned ABITS    = 4,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic             SYS_CLK,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [DBITS-1:0] din,
    input  logic             clr_err,
    output logic [DBITS-1:0] dout,
    output logic             dout_valid,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [ABITS:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned    DEPTH   = 2 ** ABITS;
    localparam logic [ABITS:0] L_DEPTH = {1'b1, {ABITS{1'b0}}};
    localparam logic [ABITS:0] L_AF    = AF_LEVEL[ABITS:0];
    localparam logic [ABITS:0] L_AE    = AE_LEVEL[ABITS:0];

    logic [DBITS-1:0] r_mem [DEPTH];
    logic [ABITS-1:0] r_wr_ptr;
    logic [ABITS-1:0] r_rd_ptr;
    logic [ABITS:0]   r_count;
    logic [DBITS-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_wr_req;
    logic             w_rd_req;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_full;
    logic             w_empty;
    logic [ABITS:0]   w_count_next;

`ifdef FIFO_STROBE_EDGE_EN
    logic r_wr_d1;
    logic r_wr_d2;
    logic r_rd_d1;
    logic r_rd_d2;

    // Two-flop synchronisers for the slow strobe inputs
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            r_wr_d1 <= 1'b0;
            r_wr_d2 <= 1'b0;
            r_rd_d1 <= 1'b0;
            r_rd_d2 <= 1'b0;
        end else begin
            r_wr_d1 <= wr;
            r_wr_d2 <= r_wr_d1;
            r_rd_d1 <= rd;
            r_rd_d2 <= r_rd_d1;
        end
    end

    // Falling edge of the synchronised strobe gives a one-cycle request
    assign w_wr_req = r_wr_d2 & ~r_wr_d1;
    assign w_rd_req = r_rd_d2 & ~r_rd_d1;
`else
    assign w_wr_req = wr;
    assign w_rd_req = rd;
`endif

    assign w_full   = (r_count == L_DEPTH);
    assign w_empty  = (r_count == '0);
    // A write into a full FIFO is allowed when a read frees the head slot in the same cycle
    assign w_wr_acc = w_wr_req & (~w_full | w_rd_req);
    assign w_rd_acc = w_rd_req & ~w_empty;

    // Occupancy next-state
    always_comb begin
        w_count_next = r_count;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Storage array, not reset
    always_ff @(posedge SYS_CLK) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, count, read data and sticky error flags
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_count      <= w_count_next;
            r_dout_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // Non-blocking read returns the old word even if this slot is overwritten now
            if (w_rd_acc) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // A new error wins over a simultaneous clear
            if (w_wr_req & ~w_wr_acc) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_rd_req & ~w_rd_acc) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign dout         = r_dout;
    assign dout_valid   = r_dout_valid;
    assign count        = r_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_count <= L_AE);
    assign almost_full  = (r_count >= L_AF);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param with DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
// With FIFO_STROBE_EDGE_EN defined only the strobe-input scenario is exercised.
module tb_fifo_sync_param;

    localparam int unsigned DBITS = 8;
    localparam int unsigned ABITS = 2;

    logic             SYS_CLK;
    logic             reset;
    logic             wr;
    logic             rd;
    logic [DBITS-1:0] din;
    logic             clr_err;
    logic [DBITS-1:0] dout;
    logic             dout_valid;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [ABITS:0]   count;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_sync_param #(
        .DBITS    (DBITS),
        .ABITS    (ABITS),
        .AF_LEVEL (3),
        .AE_LEVEL (1)
    ) u_dut (
        .SYS_CLK      (SYS_CLK),
        .reset        (reset),
        .wr           (wr),
        .rd           (rd),
        .din          (din),
        .clr_err      (clr_err),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic check_flags(input string tag, input int cnt, input logic ovf, input logic unf);
        check_eq({tag, ".count"}, 32'(count), 32'(cnt));
        check_eq({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
        check_eq({tag, ".full"}, 32'(full), 32'(cnt == 4));
        check_eq({tag, ".aempty"}, 32'(almost_empty), 32'(cnt <= 1));
        check_eq({tag, ".afull"}, 32'(almost_full), 32'(cnt >= 3));
        check_eq({tag, ".ovf"}, 32'(overflow), 32'(ovf));
        check_eq({tag, ".unf"}, 32'(underflow), 32'(unf));
    endtask

    task automatic write1(input logic [7:0] d);
        wr  = 1'b1;
        din = d;
        tick();
        wr  = 1'b0;
    endtask

    task automatic read1();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [7:0] seq1 [4];
    logic [7:0] seq4 [4];

    initial begin
        reset   = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
        din     = '0;
        clr_err = 1'b0;
        seq1[0] = 8'h11; seq1[1] = 8'h22; seq1[2] = 8'h33; seq1[3] = 8'h44;
        seq4[0] = 8'hA1; seq4[1] = 8'hA2; seq4[2] = 8'hA3; seq4[3] = 8'hAA;
        tick();
        tick();

        // Reset state
        check_flags("rst", 0, 1'b0, 1'b0);
        check_eq("rst.dout", 32'(dout), 32'h0);
        check_eq("rst.dv", 32'(dout_valid), 32'h0);
        reset = 1'b0;

`ifdef FIFO_STROBE_EDGE_EN
        // Held strobe produces a single write on its falling edge
        wr  = 1'b1;
        din = 8'h77;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check_eq("edge.held_count", 32'(count), 32'h0);
        wr = 1'b0;
        tick();
        tick();
        tick();
        check_eq("edge.count3", 32'(count), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        check_eq("edge.count_later", 32'(count), 32'h1);
        rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check_eq("edge.dout", 32'(dout), 32'h77);
        check_eq("edge.count_end", 32'(count), 32'h0);
        check_eq("edge.unf", 32'(underflow), 32'h0);
`else
        // 1: fill to full, then a rejected write
        for (int i = 0; i < 4; i++) begin
            write1(seq1[i]);
            check_flags($sformatf("t1.w%0d", i), i + 1, 1'b0, 1'b0);
        end
        write1(8'h55);
        check_flags("t1.ovf", 4, 1'b1, 1'b0);

        // 2: drain in order, then a rejected read
        for (int i = 0; i < 4; i++) begin
            read1();
            check_eq($sformatf("t2.dout%0d", i), 32'(dout), 32'(seq1[i]));
            check_eq($sformatf("t2.dv%0d", i), 32'(dout_valid), 32'h1);
            check_eq($sformatf("t2.cnt%0d", i), 32'(count), 32'(3 - i));
        end
        read1();
        check_flags("t2.unf", 0, 1'b1, 1'b1);
        check_eq("t2.dout_hold", 32'(dout), 32'h44);
        check_eq("t2.dv_none", 32'(dout_valid), 32'h0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check_flags("t2.clr", 0, 1'b0, 1'b0);

        // 3: interleaved traffic wrapping the pointers
        for (int i = 0; i < 10; i++) begin
            write1(8'(i));
            read1();
            check_eq($sformatf("t3.dout%0d", i), 32'(dout), 32'(i));
            check_eq($sformatf("t3.dv%0d", i), 32'(dout_valid), 32'h1);
        end
        check_flags("t3.end", 0, 1'b0, 1'b0);

        // 4a: simultaneous read/write while full
        for (int i = 0; i < 4; i++) begin
            write1(8'hA0 + 8'(i));
        end
        wr  = 1'b1;
        rd  = 1'b1;
        din = 8'hAA;
        tick();
        wr  = 1'b0;
        rd  = 1'b0;
        check_eq("t4.full_dout", 32'(dout), 32'hA0);
        check_eq("t4.full_dv", 32'(dout_valid), 32'h1);
        check_flags("t4.full", 4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            read1();
            check_eq($sformatf("t4.drain%0d", i), 32'(dout), 32'(seq4[i]));
        end
        check_flags("t4.drained", 0, 1'b0, 1'b0);

        // 4b: simultaneous read/write while empty, no fall-through
        wr  = 1'b1;
        rd  = 1'b1;
        din = 8'h5C;
        tick();
        wr  = 1'b0;
        rd  = 1'b0;
        check_flags("t4.empty_rw", 1, 1'b0, 1'b1);
        check_eq("t4.empty_dv", 32'(dout_valid), 32'h0);
        check_eq("t4.empty_dout", 32'(dout), 32'hAA);
        read1();
        check_eq("t4.next_dout", 32'(dout), 32'h5C);
        check_eq("t4.next_dv", 32'(dout_valid), 32'h1);

        // 5: asynchronous reset mid-burst clears everything without a clock edge
        write1(8'h01);
        write1(8'h02);
        check_eq("t5.pre_count", 32'(count), 32'h2);
        wr  = 1'b1;
        din = 8'h03;
        #2;
        reset = 1'b1;
        #1;
        check_flags("t5.async", 0, 1'b0, 1'b0);
        check_eq("t5.dout", 32'(dout), 32'h0);
        check_eq("t5.dv", 32'(dout_valid), 32'h0);
        wr = 1'b0;
        tick();
        reset = 1'b0;
        read1();
        check_eq("t5.unf_set", 32'(underflow), 32'h1);
        // Clear and a new error in the same cycle: flag stays set
        rd      = 1'b1;
        clr_err = 1'b1;
        tick();
        rd      = 1'b0;
        check_eq("t5.clr_vs_err", 32'(underflow), 32'h1);
        tick();
        clr_err = 1'b0;
        check_flags("t5.clr", 0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
